mux_2x1_stream: RTL
===================

# mux_2x1_stream

Two-input stream merger with valid/ready handshakes. Arbitrates two source channels onto one registered output channel and tags each output word with the input it came from. This is the merge counterpart of the combinational 1x2 demux: a downstream `demux_1x2` driven by `ys` can split the stream back out. Sits between two producers and a single consumer in the datapath.

## Interface
- `WIDTH`, 8, data width of every channel.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  synchronous active-low reset, sampled on `clk` rising edge.
- `d0`  input  WIDTH  source 0 data.
- `v0`  input  1  source 0 valid.
- `r0`  output  1  source 0 ready, combinational.
- `d1`  input  WIDTH  source 1 data.
- `v1`  input  1  source 1 valid.
- `r1`  output  1  source 1 ready, combinational.
- `y`  output  WIDTH  output data, registered.
- `ys`  output  1  output source tag: 0 means from `d0`, 1 means from `d1`. Registered.
- `yv`  output  1  output valid, registered.
- `yr`  input  1  output ready from the consumer.

## Operation
- Transfer on any channel occurs on a rising edge where valid and ready are both 1.
- One-entry output register. It has two states:
  - EMPTY: `yv`=0.
  - FULL: `yv`=1.
- `load = ~yv | yr`. The register accepts a new word whenever it is empty or is being drained in the same cycle.
- Grant, combinational:
  - only `v0` high: grant 0.
  - only `v1` high: grant 1.
  - both high: grant goes to `~last`, where `last` is the index of the most recently accepted source.
  - neither high: no grant.
- Ready outputs: `r0 = load & grant==0 & v0`, `r1 = load & grant==1 & v1`. At most one ready is high in any cycle.
- On an accepted input:
  - `y` takes the granted source's data.
  - `ys` takes the granted index.
  - `yv` is set to 1.
  - `last` is set to the granted index.
- If `yv & yr` and no input is accepted, `yv` is cleared. `y` and `ys` hold their stale values.
- While `yv & ~yr` (stall), `y`, `ys` and `yv` are stable. `r0` and `r1` are both 0.
- `last` changes only on an accepted input.
- Reset values: `yv`=0, `y`=0, `ys`=0, `last`=1. With `last`=1, input 0 wins the first simultaneous request.
- Reset during operation: any word held in the output register is discarded. `yv` reads 0 in the cycle after the reset edge. Ready outputs are forced to 0 while `rst_n`=0.

## Timing
- Latency is 1 cycle: data accepted at edge N appears on `y`, with `yv`=1, after edge N.
- Throughput is 1 word per cycle while `yr`=1. Back-to-back transfers have no bubble, because drain and load happen on the same edge.
- Under continuous contention with `yr`=1, the output alternates 0,1,0,1,... on `ys`.
- `r0` and `r1` depend combinationally on `yv`, `yr`, `v0`, `v1` and `last`. They have no combinational dependency on the data inputs.
- Sources must hold data and valid stable until accepted. The block never drops an accepted word.

## Configuration
- `MUX2_RR_EN` defined: round-robin arbitration on simultaneous requests, as described above.
- `MUX2_RR_EN` not defined: fixed priority. Source 0 always wins simultaneous requests. The `last` register is omitted. All other behaviour and timing are unchanged.
- Source 1 starves under continuous `v0` with fixed priority. This is accepted behaviour in that build.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `v0`=`v1`=1 → `yv`=0, `y`=0, `ys`=0, `r0`=`r1`=0. First cycle after release with `yr`=1 → `r0`=1 and `r1`=0.
- Single source: `v0`=1 with `d0`=0xA5, `v1`=0, `yr`=1 → next cycle `y`=0xA5, `ys`=0, `yv`=1. Then `v0` low → `yv`=0 one cycle later.
- Contention, `MUX2_RR_EN` defined: `d0`=0x11, `d1`=0x22, both valid for 4 words each, `yr`=1 → `ys` sequence 0,1,0,1,0,1,0,1 and `y` alternates 0x11/0x22, with `yv` high 8 consecutive cycles.
- Contention, `MUX2_RR_EN` not defined: same stimulus → 4× `ys`=0, then 4× `ys`=1.
- Backpressure: `yr`=0 for 3 cycles while FULL with `y`=0x3C → `y`=0x3C and `ys` stable, `r0`=`r1`=0. On `yr`=1 the next pending word loads on the same edge, with no bubble.
- Reset while FULL: `yv`=1, `y`=0x7E, assert `rst_n`=0 for 1 cycle → `yv`=0, `y`=0. No stale word appears after release.

Source files
------------

// File: rtl/mux_2x1_stream.sv
// Two-input valid/ready stream merger with a one-entry registered output tagged by source.
// Define MUX2_RR_EN for round-robin arbitration; otherwise source 0 has fixed priority.
module mux_2x1_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d0,
  input  logic             v0,
  output logic             r0,
  input  logic [WIDTH-1:0] d1,
  input  logic             v1,
  output logic             r1,
  output logic [WIDTH-1:0] y,
  output logic             ys,
  output logic             yv,
  input  logic             yr
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q;
  logic             ys_q;
  logic             load;
  logic             grant;
  logic             accept;

  // Drain and load share an edge, so a full register still accepts when yr is high.
  assign load = (state_q == EMPTY) | yr;

`ifdef MUX2_RR_EN
  logic last_q;

  // On contention the source that did not win last time goes next.
  assign grant = (v0 & v1) ? ~last_q : ~v0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= grant;
    end
  end
`else
  assign grant = ~v0;
`endif

  // Gating with rst_n keeps producers from handing off a word that reset would discard.
  assign r0     = rst_n & load & ~grant & v0;
  assign r1     = rst_n & load &  grant & v1;
  assign accept = r0 | r1;

  always_comb begin
    // NOTE: default assignment first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    if (accept) begin
      state_d = FULL;
    end else if (yr) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Data and tag only move on acceptance; a drained word leaves stale contents behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q  <= '0;
      ys_q <= 1'b0;
    end else if (accept) begin
      y_q  <= grant ? d1 : d0;
      ys_q <= grant;
    end
  end

  assign y  = y_q;
  assign ys = ys_q;
  assign yv = (state_q == FULL);

endmodule
